periph_bus_fabric: RTL
======================

Name: periph_bus_fabric

Overview:
- Parametrised peripheral interconnect between the core-side IO port and NUM_SLAVES peripheral controllers (flash, SDRAM, GPIO, UART, timer, ...).
- Decodes addresses through a per-slave base/mask table and registers each request.
- Runs one outstanding transaction through a small FSM, with a bus-timeout error response.
- Prioritises and registers peripheral interrupt sources into a single interrupt code for the core.

Parameters:
XLEN, 32, data/address width
NUM_SLAVES, 5, number of slave channels (1..16)
BASE_VEC, {NUM_SLAVES x XLEN}, concatenated slave base addresses; slot i at bits [i*XLEN +: XLEN]
MASK_VEC, {NUM_SLAVES x XLEN}, concatenated decode masks; slave i hits when (addr & MASK_i) == BASE_i
TIMEOUT_CYCLES, 255, max cycles in ACCESS before error; 0 disables timeout
INT_CODE_WIDTH, 4, interrupt code width
INT_CODE_VEC, {NUM_SLAVES x INT_CODE_WIDTH}, code reported for source i
INT_CODE_NONE, 0, code when no source is pending

Ports:
pclk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_addr  in  XLEN  master address
m_read  in  1  master read request, level
m_write  in  1  master write request, level
m_wdata  in  XLEN  master write data
m_byte_size  in  2  access size code, forwarded unchanged
m_rdata  out  XLEN  read data, valid while m_ready
m_ready  out  1  one-cycle completion strobe
m_err  out  1  error qualifier, valid while m_ready
s_addr  out  XLEN  registered address to all slaves
s_wdata  out  XLEN  registered write data to all slaves
s_byte_size  out  2  registered size to all slaves
s_read  out  NUM_SLAVES  per-slave read strobe, one-hot or zero
s_write  out  NUM_SLAVES  per-slave write strobe, one-hot or zero
s_rdata  in  NUM_SLAVES*XLEN  concatenated slave read data
s_ready  in  NUM_SLAVES  per-slave ready
irq_src  in  NUM_SLAVES  level interrupt sources
irq_code  out  INT_CODE_WIDTH  registered highest-priority pending code

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all outputs 0; irq_code=INT_CODE_NONE; timeout counter 0. Reset mid-transaction aborts silently, with no m_ready pulse.
- FSM states and transitions:
  - IDLE: on (m_read|m_write), latch addr/wdata/size/direction and decode.
  - Both m_read and m_write asserted: decode error.
  - Multiple hits: lowest index wins.
  - No hit or decode error: go to DONE with err=1, rdata=0.
  - Otherwise go to ACCESS with sel=hit index.
- ACCESS:
  - s_read[sel] or s_write[sel] is held high every cycle; the other strobes are 0.
  - Counter increments each cycle.
  - s_ready[sel]=1: capture s_rdata[sel] (0 for writes), err=0, deassert strobes, go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no ready: deassert strobes, err=1, rdata=0, go to DONE.
  - s_ready of a non-selected slave is ignored.
- DONE: m_ready=1 for exactly one cycle with registered m_rdata/m_err, then IDLE.
  - Master must drop its request in the DONE cycle. A request still high in the following IDLE cycle is a new transaction.
- Latency: request sampled at edge N → strobe from N+1. Slave ready sampled at edge N+1+k → m_ready high during cycle N+2+k. Minimum 3 cycles request-to-ready. Unmapped access: m_ready in cycle N+1.
- Master inputs changing while busy have no effect, since all slave-side signals come from latched copies.
- Interrupts:
  - irq_code is registered every cycle: INT_CODE_VEC[i] for the lowest-index asserted irq_src[i], else INT_CODE_NONE.
  - Latency is 1 cycle.
  - The source bus is level-sensitive, with no latching beyond this one register.
- Widths: the counter is ceil(log2(TIMEOUT_CYCLES+1)) bits and saturates, with no wrap.

Decomposition:
- Shared package/config include: XLEN, default BASE/MASK constants per peripheral (FLASH, SDRAM, GPIO, UART, TIMER), INT_CODE_* values, FSM state encodings (IDLE/ACCESS/DONE).
- One natural sub-module, periph_addr_decoder: combinational base/mask match plus lowest-index priority encode, with hit-valid and index outputs. It is reused for the interrupt priority encode.

Test Plan:
- Read slave 2 (base 0x1000_0000, mask 0xF000_0000) at 0x1000_0010; slave readies after 2 cycles with 0xDEADBEEF → s_read=5'b00100 for 3 cycles; m_ready one cycle with m_rdata=0xDEADBEEF, m_err=0; total 5 cycles.
- Write 0x55 to an unmapped 0xE000_0000 → no s_* strobe; m_ready at cycle N+1 with m_err=1, m_rdata=0.
- TIMEOUT_CYCLES=8, slave never readies → strobe high for exactly 8 cycles, then m_ready with m_err=1.
- m_read and m_write high together → decode error response; no slave strobed.
- irq_src=5'b10100 → irq_code=INT_CODE_VEC[2] one cycle later; drop bit 2 → INT_CODE_VEC[4]; all zero → INT_CODE_NONE.
- Assert rst_n=0 mid-ACCESS → strobes and m_ready go to 0 immediately; after release, a new read completes normally.

Source files
------------

// File: rtl/periph_bus_fabric_pkg.sv
// Shared constants for the peripheral bus fabric: default memory map,
// interrupt codes and FSM state encodings.
package periph_bus_fabric_pkg;

  localparam int unsigned BUS_XLEN = 32;
  localparam int unsigned DEFAULT_NUM_SLAVES = 5;

  localparam logic [BUS_XLEN-1:0] FLASH_BASE = 32'h0000_0000;
  localparam logic [BUS_XLEN-1:0] FLASH_MASK = 32'hF000_0000;
  localparam logic [BUS_XLEN-1:0] SDRAM_BASE = 32'h8000_0000;
  localparam logic [BUS_XLEN-1:0] SDRAM_MASK = 32'hC000_0000;
  localparam logic [BUS_XLEN-1:0] GPIO_BASE  = 32'h1000_0000;
  localparam logic [BUS_XLEN-1:0] GPIO_MASK  = 32'hF000_0000;
  localparam logic [BUS_XLEN-1:0] UART_BASE  = 32'h2000_0000;
  localparam logic [BUS_XLEN-1:0] UART_MASK  = 32'hFFFF_0000;
  localparam logic [BUS_XLEN-1:0] TIMER_BASE = 32'h2001_0000;
  localparam logic [BUS_XLEN-1:0] TIMER_MASK = 32'hFFFF_0000;

  // Slot 0 sits in the least-significant word.
  localparam logic [DEFAULT_NUM_SLAVES*BUS_XLEN-1:0] DEFAULT_BASE_VEC =
    {TIMER_BASE, UART_BASE, GPIO_BASE, SDRAM_BASE, FLASH_BASE};
  localparam logic [DEFAULT_NUM_SLAVES*BUS_XLEN-1:0] DEFAULT_MASK_VEC =
    {TIMER_MASK, UART_MASK, GPIO_MASK, SDRAM_MASK, FLASH_MASK};

  localparam int unsigned DEFAULT_INT_CODE_WIDTH = 4;
  localparam logic [DEFAULT_INT_CODE_WIDTH-1:0] INT_CODE_NONE_DEF = 4'd0;
  localparam logic [DEFAULT_INT_CODE_WIDTH-1:0] INT_CODE_FLASH = 4'd1;
  localparam logic [DEFAULT_INT_CODE_WIDTH-1:0] INT_CODE_SDRAM = 4'd2;
  localparam logic [DEFAULT_INT_CODE_WIDTH-1:0] INT_CODE_GPIO  = 4'd3;
  localparam logic [DEFAULT_INT_CODE_WIDTH-1:0] INT_CODE_UART  = 4'd4;
  localparam logic [DEFAULT_INT_CODE_WIDTH-1:0] INT_CODE_TIMER = 4'd5;
  localparam logic [DEFAULT_NUM_SLAVES*DEFAULT_INT_CODE_WIDTH-1:0] DEFAULT_INT_CODE_VEC =
    {INT_CODE_TIMER, INT_CODE_UART, INT_CODE_GPIO, INT_CODE_SDRAM, INT_CODE_FLASH};

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE   = 2'd0;
  localparam fsm_state_t ST_ACCESS = 2'd1;
  localparam fsm_state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/periph_addr_decoder.sv
// Combinational base/mask match across NUM entries with lowest-index priority.
module periph_addr_decoder #(
  parameter int unsigned AW    = 32,
  parameter int unsigned NUM   = 5,
  parameter int unsigned IDX_W = 3,
  parameter logic [NUM*AW-1:0] BASE_VEC = '0,
  parameter logic [NUM*AW-1:0] MASK_VEC = '0
) (
  input  logic [AW-1:0]    addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!hit && ((addr & MASK_VEC[i*AW +: AW]) == BASE_VEC[i*AW +: AW])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/periph_bus_fabric.sv
// Single-outstanding peripheral interconnect with address decode, bus timeout
// and a registered interrupt priority encoder.
module periph_bus_fabric
  import periph_bus_fabric_pkg::*;
#(
  parameter int unsigned XLEN           = BUS_XLEN,
  parameter int unsigned NUM_SLAVES     = DEFAULT_NUM_SLAVES,
  parameter logic [NUM_SLAVES*XLEN-1:0] BASE_VEC = DEFAULT_BASE_VEC,
  parameter logic [NUM_SLAVES*XLEN-1:0] MASK_VEC = DEFAULT_MASK_VEC,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned INT_CODE_WIDTH = DEFAULT_INT_CODE_WIDTH,
  parameter logic [NUM_SLAVES*INT_CODE_WIDTH-1:0] INT_CODE_VEC = DEFAULT_INT_CODE_VEC,
  parameter logic [INT_CODE_WIDTH-1:0] INT_CODE_NONE = '0
) (
  input  logic                       pclk,
  input  logic                       rst_n,
  input  logic [XLEN-1:0]            m_addr,
  input  logic                       m_read,
  input  logic                       m_write,
  input  logic [XLEN-1:0]            m_wdata,
  input  logic [1:0]                 m_byte_size,
  output logic [XLEN-1:0]            m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic [XLEN-1:0]            s_addr,
  output logic [XLEN-1:0]            s_wdata,
  output logic [1:0]                 s_byte_size,
  output logic [NUM_SLAVES-1:0]      s_read,
  output logic [NUM_SLAVES-1:0]      s_write,
  input  logic [NUM_SLAVES*XLEN-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [NUM_SLAVES-1:0]      irq_src,
  output logic [INT_CODE_WIDTH-1:0]  irq_code
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Interrupt priority reuses the address decoder: entry i matches when bit i is set.
  function automatic logic [NUM_SLAVES*NUM_SLAVES-1:0] onehot_table();
    logic [NUM_SLAVES*NUM_SLAVES-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) t[i*NUM_SLAVES + i] = 1'b1;
    return t;
  endfunction

  localparam logic [NUM_SLAVES*NUM_SLAVES-1:0] IRQ_TABLE = onehot_table();

  fsm_state_t       state;
  logic [IDX_W-1:0] sel;
  logic             is_write;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             irq_hit;
  logic [IDX_W-1:0] irq_idx;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic             sel_ready;
  logic             timed_out;

  periph_addr_decoder #(
    .AW       (XLEN),
    .NUM      (NUM_SLAVES),
    .IDX_W    (IDX_W),
    .BASE_VEC (BASE_VEC),
    .MASK_VEC (MASK_VEC)
  ) u_addr_dec (
    .addr (m_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  periph_addr_decoder #(
    .AW       (NUM_SLAVES),
    .NUM      (NUM_SLAVES),
    .IDX_W    (IDX_W),
    .BASE_VEC (IRQ_TABLE),
    .MASK_VEC (IRQ_TABLE)
  ) u_irq_dec (
    .addr (irq_src),
    .hit  (irq_hit),
    .idx  (irq_idx)
  );

  always_comb begin
    dec_onehot = NUM_SLAVES'(1) << dec_idx;
    cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    sel_ready  = s_ready[sel];
    timed_out  = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sel         <= '0;
      is_write    <= 1'b0;
      cnt         <= '0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_byte_size <= '0;
      s_read      <= '0;
      s_write     <= '0;
      m_ready     <= 1'b0;
      m_rdata     <= '0;
      m_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_read || m_write) begin
            s_addr      <= m_addr;
            s_wdata     <= m_wdata;
            s_byte_size <= m_byte_size;
            is_write    <= m_write;
            sel         <= dec_idx;
            cnt         <= '0;
            if ((m_read && m_write) || !dec_hit) begin
              state   <= ST_DONE;
              m_ready <= 1'b1;
              m_err   <= 1'b1;
              m_rdata <= '0;
            end else begin
              state   <= ST_ACCESS;
              s_read  <= m_read  ? dec_onehot : '0;
              s_write <= m_write ? dec_onehot : '0;
            end
          end
        end
        ST_ACCESS: begin
          cnt <= cnt_inc;
          // Ready wins over a timeout landing on the same edge.
          if (sel_ready) begin
            s_read  <= '0;
            s_write <= '0;
            m_ready <= 1'b1;
            m_err   <= 1'b0;
            m_rdata <= is_write ? '0 : s_rdata[sel*XLEN +: XLEN];
            state   <= ST_DONE;
          end else if (timed_out) begin
            s_read  <= '0;
            s_write <= '0;
            m_ready <= 1'b1;
            m_err   <= 1'b1;
            m_rdata <= '0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          m_ready <= 1'b0;
          m_err   <= 1'b0;
          m_rdata <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) irq_code <= INT_CODE_NONE;
    else        irq_code <= irq_hit ? INT_CODE_VEC[irq_idx*INT_CODE_WIDTH +: INT_CODE_WIDTH]
                                    : INT_CODE_NONE;
  end

endmodule
